// File: rtl/ssd_page_scheduler_if.sv
// Handshake/data bundle between the status sources, the alert requester and
// the page scheduler that feeds the two-digit PmodSSD display.
interface ssd_page_scheduler_if #(
  parameter int NUM_SRC = 4
);
  logic [8*NUM_SRC-1:0] i_src_values;
  logic [NUM_SRC-1:0]   i_src_en;
  logic                 i_alert_req;
  logic [7:0]           i_alert_value;
  logic                 o_alert_ack;
  logic                 o_alert_active;
  logic [2:0]           o_page_idx;
  logic [3:0]           o_value0;
  logic [3:0]           o_value1;

  modport master (
    output i_src_values, i_src_en, i_alert_req, i_alert_value,
    input  o_alert_ack, o_alert_active, o_page_idx, o_value0, o_value1
  );

  modport slave (
    input  i_src_values, i_src_en, i_alert_req, i_alert_value,
    output o_alert_ack, o_alert_active, o_page_idx, o_value0, o_value1
  );
endinterface

// File: rtl/ssd_page_scheduler.sv
// Round-robin pager over NUM_SRC status bytes with a one-shot alert override,
// driving the nibble inputs of the two-digit PmodSSD display.
module ssd_page_scheduler #(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = 20000000,
  parameter int ALERT_CYCLES = 40000000
) (
  input  logic                 i_clk_20mhz,
  input  logic                 i_rst_20mhz,
  ssd_page_scheduler_if.slave  bus
);
  localparam int DW_W = $clog2(DWELL_CYCLES + 1);
  localparam int AW_W = $clog2(ALERT_CYCLES + 1);
  localparam logic [DW_W-1:0] DWELL_LD = DW_W'(DWELL_CYCLES);
  localparam logic [AW_W-1:0] ALERT_LD = AW_W'(ALERT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_ALERT} state_t;

  state_t            r_state, w_state;
  logic [2:0]        r_page, w_page;
  logic [DW_W-1:0]   r_dwell, w_dwell;
  logic [AW_W-1:0]   r_acnt, w_acnt;
  logic [7:0]        r_aval, w_aval;
  logic              r_from_idle, w_from_idle;
  logic [7:0]        r_value, w_value;
  logic              r_ack, w_ack;
  logic              r_active;
  logic              w_accept;
  logic              w_dwell_exp;

  // Sources padded to eight slots so a 3-bit page index never runs off the end.
  logic [7:0][7:0]   w_src;
  logic [7:0]        w_en;

  for (genvar k = 0; k < 8; k++) begin : g_pad
    if (k < NUM_SRC) begin : g_on
      assign w_src[k] = bus.i_src_values[8*k +: 8];
      assign w_en[k]  = bus.i_src_en[k];
    end else begin : g_off
      assign w_src[k] = 8'h00;
      assign w_en[k]  = 1'b0;
    end
  end

  // {found, index} of the first enabled source after 'page', wrapping; may return 'page'.
  function automatic logic [3:0] f_next(input logic [2:0] page, input logic [7:0] en);
    logic [3:0] res;
    int         idx;
    res = 4'h0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      idx = (int'(page) + i) % NUM_SRC;
      if (en[3'(idx)]) res = {1'b1, 3'(idx)};
    end
    return res;
  endfunction

  logic [3:0] w_next;
  logic [3:0] w_low;

  assign w_next      = f_next(r_page, w_en);
  assign w_low       = f_next(3'(NUM_SRC - 1), w_en);
  assign w_dwell_exp = (r_dwell == DW_W'(1));
  assign w_accept    = bus.i_alert_req && (r_state != S_ALERT);

  always_comb begin
    w_state     = r_state;
    w_page      = r_page;
    w_dwell     = r_dwell;
    w_acnt      = r_acnt;
    w_aval      = r_aval;
    w_from_idle = r_from_idle;
    w_ack       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_from_idle = 1'b1;
          w_page      = 3'd0;
        end else if (w_low[3]) begin
          w_state = S_SHOW;
          w_page  = w_low[2:0];
          w_dwell = DWELL_LD;
        end
      end
      S_SHOW: begin
        if (w_accept) begin
          // The page advance due this cycle still happens; it becomes the saved page.
          w_from_idle = 1'b0;
          if (w_dwell_exp) begin
            if (w_next[3]) w_page = w_next[2:0];
            w_dwell = DWELL_LD;
          end
        end else if (!w_en[r_page]) begin
          if (w_next[3]) begin
            w_page  = w_next[2:0];
            w_dwell = DWELL_LD;
          end else begin
            w_state = S_IDLE;
            w_page  = 3'd0;
            w_dwell = '0;
          end
        end else if (w_dwell_exp) begin
          w_page  = w_next[2:0];
          w_dwell = DWELL_LD;
        end else begin
          w_dwell = r_dwell - DW_W'(1);
        end
      end
      S_ALERT: begin
        if (r_acnt == AW_W'(1)) begin
          w_acnt = '0;
          if (r_from_idle) begin
            if (w_low[3]) begin
              w_state = S_SHOW;
              w_page  = w_low[2:0];
              w_dwell = DWELL_LD;
            end else begin
              w_state = S_IDLE;
            end
          end else if (w_en[r_page]) begin
            w_state = S_SHOW;
          end else if (w_next[3]) begin
            w_state = S_SHOW;
            w_page  = w_next[2:0];
            w_dwell = DWELL_LD;
          end else begin
            w_state = S_IDLE;
            w_page  = 3'd0;
            w_dwell = '0;
          end
        end else begin
          w_acnt = r_acnt - AW_W'(1);
        end
      end
      default: begin
        w_state = S_IDLE;
        w_page  = 3'd0;
        w_dwell = '0;
        w_acnt  = '0;
      end
    endcase

    if (w_accept) begin
      w_state = S_ALERT;
      w_aval  = bus.i_alert_value;
      w_acnt  = ALERT_LD;
      w_ack   = 1'b1;
    end

    // Display is computed from the next state so it lines up with page/active.
    case (w_state)
      S_ALERT: w_value = w_aval;
      S_SHOW:  w_value = w_src[w_page];
      default: w_value = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      r_state     <= S_IDLE;
      r_page      <= 3'd0;
      r_dwell     <= '0;
      r_acnt      <= '0;
      r_aval      <= 8'h00;
      r_from_idle <= 1'b0;
      r_value     <= 8'h00;
      r_ack       <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_page      <= w_page;
      r_dwell     <= w_dwell;
      r_acnt      <= w_acnt;
      r_aval      <= w_aval;
      r_from_idle <= w_from_idle;
      r_value     <= w_value;
      r_ack       <= w_ack;
      r_active    <= (w_state == S_ALERT);
    end
  end

  assign bus.o_value0       = r_value[3:0];
  assign bus.o_value1       = r_value[7:4];
  assign bus.o_page_idx     = r_page;
  assign bus.o_alert_ack    = r_ack;
  assign bus.o_alert_active = r_active;
endmodule
